// File: rtl/pc_unit.sv
// Program counter with a two-state NORMAL/TRAP FSM, a saved exception PC,
// and registered one-cycle fault pulses for misaligned jumps, nested traps and stray returns.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              IALIGN       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_wr,
  input  logic [1:0]      npc_sel,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            in_trap,
  output logic            misalign_fault,
  output logic            double_fault,
  output logic            illegal_ret
);

  typedef enum logic {NORMAL = 1'b0, TRAP = 1'b1} state_t;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_TGT = 2'b01;
  localparam logic [1:0] SEL_TRP = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt, epc_nxt;
  logic            misalign_nxt, double_nxt, illegal_nxt;
  logic            tgt_misaligned, trap_entry;

  assign pc_plus4 = pc + XLEN'(4);
  assign in_trap  = (state == TRAP);

  // Only the low address bits matter for alignment; IALIGN=2 ignores bit 1.
  assign tgt_misaligned = (IALIGN == 2) ? target[0] : (target[1:0] != 2'b00);
  assign trap_entry     = (npc_sel == SEL_TRP) || (npc_sel == SEL_TGT && tgt_misaligned);

  always_comb begin
    pc_nxt       = pc;
    epc_nxt      = epc;
    state_nxt    = state;
    misalign_nxt = 1'b0;
    double_nxt   = 1'b0;
    illegal_nxt  = 1'b0;
    if (pc_wr) begin
      if (trap_entry) begin
        pc_nxt       = TRAP_VECTOR;
        misalign_nxt = (npc_sel == SEL_TGT);
        if (state == NORMAL) begin
          epc_nxt   = pc;
          state_nxt = TRAP;
        end else begin
          double_nxt = 1'b1;
        end
      end else begin
        case (npc_sel)
          SEL_SEQ: pc_nxt = pc_plus4;
          SEL_TGT: pc_nxt = target;
          SEL_RET: begin
            if (state == TRAP) begin
              pc_nxt    = epc;
              state_nxt = NORMAL;
            end else begin
              illegal_nxt = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= NORMAL;
      pc             <= RESET_VECTOR;
      epc            <= '0;
      misalign_fault <= 1'b0;
      double_fault   <= 1'b0;
      illegal_ret    <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      epc            <= epc_nxt;
      misalign_fault <= misalign_nxt;
      double_fault   <= double_nxt;
      illegal_ret    <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: an IALIGN=4 instance plus an IALIGN=2 instance on shared inputs.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_wr;
  logic [1:0]  npc_sel;
  logic [31:0] target;
  logic [31:0] pc, pc_plus4, epc;
  logic        in_trap, misalign_fault, double_fault, illegal_ret;
  logic [31:0] pc2, pc_plus4_2, epc2;
  logic        in_trap2, misalign_fault2, double_fault2, illegal_ret2;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_unit #(.IALIGN(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_wr(pc_wr), .npc_sel(npc_sel), .target(target),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .in_trap(in_trap),
    .misalign_fault(misalign_fault), .double_fault(double_fault), .illegal_ret(illegal_ret)
  );

  pc_unit #(.IALIGN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pc_wr(pc_wr), .npc_sel(npc_sel), .target(target),
    .pc(pc2), .pc_plus4(pc_plus4_2), .epc(epc2), .in_trap(in_trap2),
    .misalign_fault(misalign_fault2), .double_fault(double_fault2), .illegal_ret(illegal_ret2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic wr, input logic [1:0] sel, input logic [31:0] tgt);
    pc_wr = wr; npc_sel = sel; target = tgt;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; pc_wr = 1'b0; npc_sel = 2'b00; target = '0;
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_trap", {31'b0, in_trap}, 32'h0);
    chk("rst_pulses", {29'b0, misalign_fault, double_fault, illegal_ret}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first edge after release acts normally; counting 0,4,8,12
    step(1'b1, 2'b00, 32'h0); chk("seq1", pc, 32'h4);
    step(1'b1, 2'b00, 32'h0); chk("seq2", pc, 32'h8);
    step(1'b1, 2'b00, 32'h0); chk("seq3", pc, 32'hC);
    chk("seq_plus4", pc_plus4, 32'h10);

    // jumps and misaligned jump
    step(1'b1, 2'b01, 32'h40);  chk("jmp40", pc, 32'h40);
    step(1'b1, 2'b01, 32'h200); chk("jmp200", pc, 32'h200);
    step(1'b1, 2'b01, 32'h202);
    chk("mis_pc", pc, 32'h100);
    chk("mis_epc", epc, 32'h200);
    chk("mis_trap", {31'b0, in_trap}, 32'h1);
    chk("mis_pulse", {31'b0, misalign_fault}, 32'h1);
    chk("mis_dbl", {31'b0, double_fault}, 32'h0);
    chk("ia2_pc", pc2, 32'h202);
    chk("ia2_nofault", {30'b0, misalign_fault2, in_trap2}, 32'h0);
    step(1'b0, 2'b01, 32'h202);
    chk("mis_pulse_end", {31'b0, misalign_fault}, 32'h0);
    chk("mis_hold", pc, 32'h100);
    step(1'b1, 2'b11, 32'h0);
    chk("ret_pc", pc, 32'h200);
    chk("ret_trap", {31'b0, in_trap}, 32'h0);

    // trap, double fault, return
    step(1'b1, 2'b01, 32'h80);
    step(1'b1, 2'b10, 32'h0);
    chk("trap_pc", pc, 32'h100);
    chk("trap_epc", epc, 32'h80);
    chk("trap_in", {31'b0, in_trap}, 32'h1);
    step(1'b1, 2'b10, 32'h0);
    chk("dbl_pc", pc, 32'h100);
    chk("dbl_epc", epc, 32'h80);
    chk("dbl_pulse", {31'b0, double_fault}, 32'h1);
    step(1'b0, 2'b10, 32'h0);
    chk("dbl_pulse_end", {31'b0, double_fault}, 32'h0);
    step(1'b1, 2'b01, 32'h3);
    chk("dblmis_pulses", {30'b0, misalign_fault, double_fault}, 32'h3);
    chk("dblmis_epc", epc, 32'h80);
    chk("dblmis_trap", {31'b0, in_trap}, 32'h1);
    step(1'b1, 2'b11, 32'h0);
    chk("ret2_pc", pc, 32'h80);
    chk("ret2_trap", {31'b0, in_trap}, 32'h0);
    chk("ret2_pulses", {29'b0, misalign_fault, double_fault, illegal_ret}, 32'h0);

    // return outside trap, then idle
    step(1'b1, 2'b01, 32'h10);
    step(1'b1, 2'b11, 32'h0);
    chk("ill_pc", pc, 32'h10);
    chk("ill_epc", epc, 32'h80);
    chk("ill_pulse", {31'b0, illegal_ret}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00, 32'h0);
      chk("idle_pc", pc, 32'h10);
      chk("idle_out", {29'b0, misalign_fault, double_fault, illegal_ret}, 32'h0);
      chk("idle_epc", epc, 32'h80);
    end

    // wrap-around
    step(1'b1, 2'b01, 32'hFFFF_FFFC);
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    step(1'b1, 2'b00, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // async reset while in TRAP with an update pending
    step(1'b1, 2'b10, 32'h0);
    chk("pre_rst_trap", {31'b0, in_trap}, 32'h1);
    pc_wr = 1'b1; npc_sel = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_epc", epc, 32'h0);
    chk("arst_trap", {31'b0, in_trap}, 32'h0);
    @(posedge clk); #1;
    chk("arst_hold", pc, 32'h0);
    rst_n = 1'b1;
    step(1'b1, 2'b00, 32'h0);
    chk("post_rst_pc", pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of all address ports and registers.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: PC value after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100: PC value on trap entry.
REQ-004 SHALL have parameter IALIGN, default 4: instruction alignment in bytes; legal values are 2 and 4 only.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pc_wr  input  1  update enable; when 1, the next PC is committed on the clock edge.
REQ-008 SHALL have port npc_sel  input  2  next-PC source: 00 sequential, 01 target, 10 trap, 11 return.
REQ-009 SHALL have port target  input  XLEN  branch/jump target address.
REQ-010 SHALL have port pc  output  XLEN  current PC register.
REQ-011 SHALL have port pc_plus4  output  XLEN  combinational pc + 4, modulo 2^XLEN.
REQ-012 SHALL have port epc  output  XLEN  saved exception PC register.
REQ-013 SHALL have port in_trap  output  1  1 while the FSM is in state TRAP.
REQ-014 SHALL have port misalign_fault  output  1  registered one-cycle pulse.
REQ-015 SHALL have port double_fault  output  1  registered one-cycle pulse.
REQ-016 SHALL have port illegal_ret  output  1  registered one-cycle pulse.

Function
REQ-017 SHALL implement a two-state FSM, NORMAL and TRAP; in_trap SHALL equal (state == TRAP).
REQ-018 When pc_wr=0, pc, epc and state SHALL hold, and all three pulse outputs SHALL be 0 in the following cycle.
REQ-019 pc_wr=1, sel=00: pc <= pc + 4, with wrap-around from 2^XLEN-4 to 0; state unchanged.
REQ-020 pc_wr=1, sel=01, target mod IALIGN == 0: pc <= target; state unchanged.
REQ-021 pc_wr=1, sel=01, target mod IALIGN != 0: a misaligned jump takes the trap path of REQ-022/REQ-023 (including a double fault when already in TRAP) and additionally asserts misalign_fault=1 for one cycle.
REQ-022 pc_wr=1, sel=10 in NORMAL: epc <= pc, pc <= TRAP_VECTOR, state <= TRAP.
REQ-023 Trap entry (sel=10 or misaligned target) in TRAP: pc <= TRAP_VECTOR, epc unchanged, state stays TRAP, double_fault=1 for one cycle.
REQ-024 pc_wr=1, sel=11 in TRAP: pc <= epc, state <= NORMAL, epc unchanged.
REQ-025 pc_wr=1, sel=11 in NORMAL: pc, epc and state hold, and illegal_ret=1 for one cycle.
REQ-026 Pulse outputs SHALL be registered; each SHALL be 1 exactly in the cycle after the triggering edge and 0 otherwise.
REQ-027 The alignment check SHALL use only bits [1:0] of target for IALIGN=4, and only bit [0] for IALIGN=2.
REQ-028 epc SHALL only ever capture a pc value, never target; epc is therefore always aligned.
REQ-029 All arithmetic SHALL be unsigned XLEN-bit; the carry out of pc + 4 SHALL be discarded.
REQ-030 The block SHALL contain no combinational path from inputs to pc, epc, in_trap or the pulse outputs; pc_plus4 depends only on pc.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force pc=RESET_VECTOR, epc=0, state=NORMAL, in_trap=0, and all pulses to 0.
REQ-032 Reset asserted mid-operation (including in TRAP) SHALL discard the pending update; the first edge after rst_n rises SHALL act on the inputs normally.
REQ-033 With pc_wr=1, sel=00 at the first edge after reset release, pc SHALL become RESET_VECTOR+4.

Verification
REQ-034 Reset, then 3 edges with pc_wr=1, sel=00 -> pc = 0, 4, 8, 12; pc_plus4 = 16.
REQ-035 pc=0x40, sel=01, target=0x200 -> pc=0x200; sel=01, target=0x202 (IALIGN=4) -> pc=0x100, epc=0x200, in_trap=1, misalign_fault=1 for one cycle.
REQ-036 pc=0x80, sel=10 -> pc=0x100, epc=0x80; then sel=10 again -> pc=0x100, epc=0x80, double_fault=1; then sel=11 -> pc=0x80, in_trap=0.
REQ-037 In NORMAL with pc=0x10, sel=11 -> pc=0x10, illegal_ret=1 for one cycle; with pc_wr=0 for 5 cycles -> all outputs hold and pulses stay 0.
REQ-038 Force pc=0xFFFF_FFFC, sel=00 -> pc=0x0000_0000 (wrap); with IALIGN=2, target=0x202 -> pc=0x202 and no fault.
REQ-039 In TRAP, drive rst_n low between clock edges -> pc=RESET_VECTOR, epc=0, in_trap=0 asynchronously, before the next edge.
